// File: rtl/pc_sequencer.sv
// Program counter sequencer: issues per-cycle PCL/PCH load, hold, increment and
// decrement controls for INC, BRANCH, JUMP and VECTOR operations. It also adds
// the page-fix cycle when a branch crosses into another page.
module pc_sequencer #(
    parameter logic [7:0] VEC_PAGE = 8'hFF,
    parameter logic [7:0] NMI_LO   = 8'hFA,
    parameter logic [7:0] RST_LO   = 8'hFC,
    parameter logic [7:0] IRQ_LO   = 8'hFE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_op,
    input  logic       branch_taken,
    input  logic       offset_neg,
    input  logic [1:0] vec_id,
    input  logic       pclc,
    output logic       cmd_ready,
    output logic       done,
    output logic       pcl_pcl,
    output logic       adl_pcl,
    output logic       pcl_inc,
    output logic       pch_pch,
    output logic       adh_pch,
    output logic       pch_inc,
    output logic       pch_dec,
    output logic       vec_en,
    output logic [7:0] vec_adl,
    output logic [7:0] vec_adh
);

    typedef enum logic [3:0] {
        StIdle,
        StInc,
        StBrAdd,
        StBrFix,
        StJmpLo,
        StJmpHi,
        StVecLo,
        StVecHi,
        StNop
    } state_e;

    state_e     state_q, state_d;
    logic       neg_q, neg_d;
    logic [1:0] vec_id_q, vec_id_d;
    logic [7:0] vec_base;

    // Low byte of the selected vector; id 3 aliases to IRQ.
    always_comb begin
        unique case (vec_id_q)
            2'd0:    vec_base = NMI_LO;
            2'd1:    vec_base = RST_LO;
            default: vec_base = IRQ_LO;
        endcase
    end

    // State register and operand capture, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            neg_q    <= 1'b0;
            vec_id_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            neg_q    <= neg_d;
            vec_id_q <= vec_id_d;
        end
    end

    // Next-state and output decode; every output is forced to 0 during reset.
    always_comb begin
        state_d   = state_q;
        neg_d     = neg_q;
        vec_id_d  = vec_id_q;
        cmd_ready = 1'b0;
        done      = 1'b0;
        adl_pcl   = 1'b0;
        pcl_inc   = 1'b0;
        adh_pch   = 1'b0;
        pch_inc   = 1'b0;
        pch_dec   = 1'b0;
        vec_en    = 1'b0;
        vec_adl   = 8'h00;
        vec_adh   = 8'h00;
        pcl_pcl   = 1'b0;
        pch_pch   = 1'b0;

        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        neg_d    = offset_neg;
                        vec_id_d = vec_id;
                        unique case (cmd_op)
                            3'd0:    state_d = StInc;
                            3'd1:    state_d = branch_taken ? StBrAdd : StNop;
                            3'd2:    state_d = StJmpLo;
                            3'd3:    state_d = StVecLo;
                            default: state_d = StNop;
                        endcase
                    end
                end
                StInc: begin
                    pcl_inc = 1'b1;
                    pch_inc = pclc;
                    done    = 1'b1;
                    state_d = StIdle;
                end
                StBrAdd: begin
                    adl_pcl = 1'b1;
                    // Carry without a negative offset, or no borrow-cancel with one,
                    // means the target lies in the adjacent page.
                    if (pclc ^ neg_q) begin
                        state_d = StBrFix;
                    end else begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end
                end
                StBrFix: begin
                    pch_inc = ~neg_q;
                    pch_dec = neg_q;
                    done    = 1'b1;
                    state_d = StIdle;
                end
                StJmpLo: begin
                    adl_pcl = 1'b1;
                    state_d = StJmpHi;
                end
                StJmpHi: begin
                    adh_pch = 1'b1;
                    done    = 1'b1;
                    state_d = StIdle;
                end
                StVecLo: begin
                    vec_en  = 1'b1;
                    vec_adh = VEC_PAGE;
                    vec_adl = vec_base;
                    adl_pcl = 1'b1;
                    state_d = StVecHi;
                end
                StVecHi: begin
                    vec_en  = 1'b1;
                    vec_adh = VEC_PAGE;
                    vec_adl = vec_base + 8'd1;
                    adh_pch = 1'b1;
                    done    = 1'b1;
                    state_d = StIdle;
                end
                StNop: begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
            pcl_pcl = ~adl_pcl;
            pch_pch = ~(adh_pch | pch_inc | pch_dec);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected output vectors.
module tb_pc_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic       branch_taken;
    logic       offset_neg;
    logic [1:0] vec_id;
    logic       pclc;
    logic       cmd_ready;
    logic       done;
    logic       pcl_pcl;
    logic       adl_pcl;
    logic       pcl_inc;
    logic       pch_pch;
    logic       adh_pch;
    logic       pch_inc;
    logic       pch_dec;
    logic       vec_en;
    logic [7:0] vec_adl;
    logic [7:0] vec_adh;

    int checks;
    int errors;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .branch_taken (branch_taken),
        .offset_neg   (offset_neg),
        .vec_id       (vec_id),
        .pclc         (pclc),
        .cmd_ready    (cmd_ready),
        .done         (done),
        .pcl_pcl      (pcl_pcl),
        .adl_pcl      (adl_pcl),
        .pcl_inc      (pcl_inc),
        .pch_pch      (pch_pch),
        .adh_pch      (adh_pch),
        .pch_inc      (pch_inc),
        .pch_dec      (pch_dec),
        .vec_en       (vec_en),
        .vec_adl      (vec_adl),
        .vec_adh      (vec_adh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-vector order: rdy done pcl_pcl adl_pcl pcl_inc pch_pch adh_pch
    // pch_inc pch_dec vec_en vec_adl vec_adh.
    function automatic logic [25:0] ev(input logic rdy, input logic dn, input logic pp,
                                       input logic ap, input logic pi, input logic hh,
                                       input logic ah, input logic hi, input logic hd,
                                       input logic ve, input logic [7:0] adl,
                                       input logic [7:0] adh);
        return {rdy, dn, pp, ap, pi, hh, ah, hi, hd, ve, adl, adh};
    endfunction

    task automatic chk(input string tag, input logic [25:0] exp_v);
        logic [25:0] obs;
        obs = {cmd_ready, done, pcl_pcl, adl_pcl, pcl_inc, pch_pch, adh_pch, pch_inc,
               pch_dec, vec_en, vec_adl, vec_adh};
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op in IDLE, confirm ready, and step into the op's first cycle.
    task automatic issue(input logic [2:0] op, input logic tk, input logic ng,
                         input logic [1:0] vid);
        cmd_op       = op;
        branch_taken = tk;
        offset_neg   = ng;
        vec_id       = vid;
        cmd_valid    = 1'b1;
        #1;
        chk("accept", ev(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
        tick();
        cmd_valid    = 1'b0;
        branch_taken = 1'b0;
        offset_neg   = 1'b0;
        vec_id       = 2'd0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        cmd_valid    = 1'b1;
        cmd_op       = 3'd0;
        branch_taken = 1'b0;
        offset_neg   = 1'b0;
        vec_id       = 2'd0;
        pclc         = 1'b1;

        tick();
        tick();
        chk("reset_outputs", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        rst       = 1'b0;
        cmd_valid = 1'b0;
        pclc      = 1'b0;
        #1;
        chk("idle_after_reset", ev(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));

        // INC without and with PCL carry
        issue(3'd0, 0, 0, 2'd0);
        pclc = 1'b0; #1;
        chk("inc_nocarry", ev(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00));
        tick();
        issue(3'd0, 0, 0, 2'd0);
        pclc = 1'b1; #1;
        chk("inc_carry", ev(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00));
        tick();
        pclc = 1'b0;

        // Taken branch, positive offset, same page
        issue(3'd1, 1, 0, 2'd0);
        pclc = 1'b0; #1;
        chk("br_pos_same", ev(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
        tick();

        // Taken branch, positive offset, page cross
        issue(3'd1, 1, 0, 2'd0);
        pclc = 1'b1; #1;
        chk("br_pos_add", ev(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
        tick();
        pclc = 1'b0; #1;
        chk("br_pos_fix", ev(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00));
        tick();

        // Taken branch, negative offset, borrow (page cross)
        issue(3'd1, 1, 1, 2'd0);
        pclc = 1'b0; #1;
        chk("br_neg_add", ev(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
        tick();
        pclc = 1'b1; #1;
        chk("br_neg_fix", ev(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00));
        tick();

        // Taken branch, negative offset, carry means same page
        issue(3'd1, 1, 1, 2'd0);
        pclc = 1'b1; #1;
        chk("br_neg_same", ev(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
        tick();
        pclc = 1'b0;

        // Not-taken branch; request during NOP must be dropped
        issue(3'd1, 0, 0, 2'd0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        #1;
        chk("br_not_taken", ev(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("nop_req_dropped", ev(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));

        // Opcode 6 is a NOP
        issue(3'd6, 0, 0, 2'd0);
        chk("op6_nop", ev(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
        tick();

        // Vectors: RESET, id 3 (IRQ), NMI
        issue(3'd3, 0, 0, 2'd1);
        chk("vec_rst_lo", ev(0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 8'hFC, 8'hFF));
        tick();
        chk("vec_rst_hi", ev(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 8'hFD, 8'hFF));
        tick();
        issue(3'd3, 0, 0, 2'd3);
        chk("vec_irq_lo", ev(0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 8'hFE, 8'hFF));
        tick();
        chk("vec_irq_hi", ev(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 8'hFF, 8'hFF));
        tick();
        issue(3'd3, 0, 0, 2'd0);
        chk("vec_nmi_lo", ev(0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 8'hFA, 8'hFF));
        tick();
        chk("vec_nmi_hi", ev(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 8'hFB, 8'hFF));
        tick();

        // Jump
        issue(3'd2, 0, 0, 2'd0);
        chk("jmp_lo", ev(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
        tick();
        chk("jmp_hi", ev(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00));
        tick();

        // Jump aborted by reset in JMP_LO
        issue(3'd2, 0, 0, 2'd0);
        rst = 1'b1; #1;
        chk("jmp_rst_lo", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        tick();
        chk("jmp_rst_held", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        rst = 1'b0; #1;
        chk("jmp_rst_idle", ev(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
        tick();
        chk("jmp_rst_stay", ev(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
